uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, start/8 data LSB-first/optional parity/stop.
// Latency: VALID appears (CLKS_PER_BIT-1)/2 + CLKS_PER_BIT*(9 or 10) + 1 cycles after the
//   first low line sample (10/11 cycles at CLKS_PER_BIT=1), plus 2 when UART_RX_SYNC_EN is defined.
// Backpressure: none; VALID is a one-cycle pulse and the outputs hold until the next frame.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   RXD          serial line, idle high
//   PARITY_MODE  00/11 none, 01 even, 10 odd (captured when a start bit is detected)
//   DATA_OUT     last received byte
//   VALID        one-cycle completion pulse
//   PARITY_ERR   parity mismatch for the frame marked by VALID
//   FRAME_ERR    stop bit sampled low for the frame marked by VALID
//   BUSY         high whenever the receiver is not idle
//
// Build option: define UART_RX_SYNC_EN to pass RXD through a 2-flop synchronizer
// (both flops reset high) before it is used as the line sample.

module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic [1:0] PARITY_MODE,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  // Reload value between consecutive bit samples.
  localparam logic [15:0] CPB_M1  = 16'(CLKS_PER_BIT - 1);
  // Extra cycles from start detection to the start-bit confirmation sample.
  localparam logic [15:0] HALF    = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] HALF_M1 = (HALF == 16'd0) ? 16'd0 : (HALF - 16'd1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  mode_q, mode_d;
  logic        perr_q, perr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_out_q, ferr_out_d;

  logic line;
  logic tick;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;
`else
  assign line = RXD;
`endif

  // A sample is taken in the cycle where the down-counter has reached zero.
  assign tick = (cnt_q == 16'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      mode_q     <= 2'b00;
      perr_q     <= 1'b0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      perr_q     <= perr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    perr_d     = perr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;

    // Bit-timing counter runs only while a sample is pending.
    if ((state_q == S_START || state_q == S_DATA || state_q == S_PARITY ||
         state_q == S_STOP) && !tick) begin
      cnt_d = cnt_q - 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!line) begin
          bit_d  = 3'd0;
          mode_d = PARITY_MODE;
          perr_d = 1'b0;
          if (HALF == 16'd0) begin
            // Start confirmation coincides with this detection sample, so
            // the first data sample is already one bit period away.
            state_d = S_DATA;
            cnt_d   = CPB_M1;
          end else begin
            state_d = S_START;
            cnt_d   = HALF_M1;
          end
        end
      end

      S_START: begin
        if (tick) begin
          if (!line) begin
            state_d = S_DATA;
            cnt_d   = CPB_M1;
          end else begin
            // Glitch on the idle line: drop it silently.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = CPB_M1;
          bit_d   = 3'(bit_q + 3'd1);
          if (bit_q == 3'd7) begin
            state_d = (mode_q == 2'b01 || mode_q == 2'b10) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          // Even: expected = XOR of data; odd (mode 10): its inverse.
          perr_d  = line != ((^shift_q) ^ mode_q[1]);
          cnt_d   = CPB_M1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tick) begin
          valid_d    = 1'b1;
          data_out_d = shift_q;
          perr_out_d = perr_q;
          ferr_out_d = !line;
          // A low stop bit may be a break; wait for the line to recover
          // so a held-low line cannot be mistaken for a new start bit.
          state_d    = line ? S_IDLE : S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        if (line) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign DATA_OUT   = data_out_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_out_q;
  assign FRAME_ERR  = ferr_out_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule
